uart_tx_fifo: RTL and testbench

- Transmit-side buffer directly upstream of the UART transmitter.
- Accepts bytes from the peripheral register interface into a synchronous FIFO.
- Launches one byte at a time into the transmitter using its en/busy handshake, so software can queue bursts without polling the transmitter's busy flag.
- Reports level, full/empty and a sticky overflow flag.

---
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that feeds a UART transmitter one byte at a time over its en/busy handshake.
// Optional low-water interrupt: define UART_TX_FIFO_THR_IRQ_EN to add thr_level and a live thr_irq.
module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16,
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    flush,
    input  logic                    ovf_clr,
    input  logic                    launch_en,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        level,
    output logic                    overflow,
    output logic                    tx_en,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_busy,
`ifdef UART_TX_FIFO_THR_IRQ_EN
    input  logic [CNT_W-1:0]        thr_level,
`endif
    output logic                    thr_irq
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNT_W-1:0]        wr_ptr_reg;
    logic [CNT_W-1:0]        rd_ptr_reg;
    logic                    tx_en_reg;
    logic [PAYLOAD_BITS-1:0] tx_data_reg;
    logic                    overflow_reg;
    logic                    push;
    logic                    pop;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    // Pointers carry one extra bit so full (MSBs differ) and empty (equal) are distinct.
    assign level = wr_ptr_reg - rd_ptr_reg;
    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);

    // A flush cycle swallows any concurrent write.
    assign push = wr_en && !full && !flush;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty && launch_en && !tx_busy && !flush) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH:    state_next = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            tx_en_reg    <= 1'b0;
            tx_data_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_en_reg <= pop;
            if (pop) begin
                tx_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
            end
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
            end
            // Setting wins over a same-cycle clear so no overflow event is lost.
            if (wr_en && full) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Storage has no reset: contents are only observable after a push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign tx_en    = tx_en_reg;
    assign tx_data  = tx_data_reg;
    assign overflow = overflow_reg;

`ifdef UART_TX_FIFO_THR_IRQ_EN
    logic thr_irq_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_irq_reg <= 1'b0;
        end else begin
            thr_irq_reg <= (level <= thr_level);
        end
    end

    assign thr_irq = thr_irq_reg;
`else
    assign thr_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple busy-for-N-cycles transmitter model.
module tb_uart_tx_fifo;

    localparam int CNT_W = 5;
`ifdef UART_TX_FIFO_THR_IRQ_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             flush = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             launch_en = 1'b1;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] level;
    logic             overflow;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic             tx_busy = 1'b0;
    logic [CNT_W-1:0] thr_level = 5'd2;
    logic             thr_irq;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.PAYLOAD_BITS(8), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .ovf_clr   (ovf_clr),
        .launch_en (launch_en),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
`ifdef UART_TX_FIFO_THR_IRQ_EN
        .thr_level (thr_level),
`endif
        .thr_irq   (thr_irq)
    );

    always #5 clk = ~clk;

    // Transmitter model: samples en at the edge, busy for busy_len cycles starting next cycle.
    int         busy_len = 1;
    int         busy_cnt = 0;
    logic       prev_en = 1'b0;
    int         busy_viol = 0;
    int         width_viol = 0;
    logic [7:0] q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
            prev_en  <= 1'b0;
        end else begin
            prev_en <= tx_en;
            if (tx_en) begin
                q.push_back(tx_data);
                $display("tx byte %02h at %0t", tx_data, $time);
                if (tx_busy) busy_viol <= busy_viol + 1;
                if (prev_en) width_viol <= width_viol + 1;
                busy_cnt <= busy_len;
                tx_busy  <= 1'b1;
            end else if (busy_cnt > 1) begin
                busy_cnt <= busy_cnt - 1;
            end else begin
                busy_cnt <= 0;
                tx_busy  <= 1'b0;
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (thr_irq !== 1'b0) begin errors++; $display("FAIL reset_thr_irq got %b want 0", thr_irq); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        busy_len = 3;
        q.delete();
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (tx_en !== 1'b0 || level !== 5'd1) begin errors++; $display("FAIL single_after_write got tx_en=%b level=%0d want 0 1", tx_en, level); end
        @(negedge clk);
        checks++; if (tx_en !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_launch got tx_en=%b data=%h want 1 a5", tx_en, tx_data); end
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_level got level=%0d empty=%b want 0 1", level, empty); end
        @(negedge clk);
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_pulse_width got tx_en=%b want 0", tx_en); end
        repeat (10) @(negedge clk);
        checks++; if (q.size() != 1 || q[0] !== 8'hA5) begin errors++; $display("FAIL single_count got %0d bytes want 1 (a5)", q.size()); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", tx_data); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [3];
        int bad;
        exp_b = '{8'h01, 8'h02, 8'h03};
        busy_len = 100;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp_b[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 1000 && q.size() < 3; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++; if (q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d pulses want 3", q.size()); end
        bad = 0;
        for (int i = 0; i < 3 && i < q.size(); i++) if (q[i] !== exp_b[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order got %0d wrong bytes want 0", bad); end
        checks++; if (busy_viol != 0 || width_viol != 0) begin errors++; $display("FAIL b2b_handshake got busy_viol=%0d width_viol=%0d want 0 0", busy_viol, width_viol); end
    endtask

    task automatic test_overflow;
        int bad;
        launch_en = 1'b0;
        busy_len = 2;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill got full=%b level=%0d ovf=%b want 1 16 0", full, level, overflow); end
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_set got ovf=%b level=%0d full=%b want 1 16 1", overflow, level, full); end
        wr_en = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        launch_en = 1'b1;
        for (int i = 0; i < 400 && q.size() < 16; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 16 && i < q.size(); i++) if (q[i] !== 8'(8'h10 + i)) bad++;
        checks++; if (q.size() != 16 || bad != 0) begin errors++; $display("FAIL ovf_contents got %0d bytes %0d wrong want 16 0", q.size(), bad); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL ovf_drained got empty=%b full=%b want 1 0", empty, full); end
    endtask

    task automatic test_flush;
        busy_len = 20;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (level !== 5'd5 || tx_busy !== 1'b1) begin errors++; $display("FAIL flush_pre got level=%0d busy=%b want 5 1", level, tx_busy); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level got level=%0d empty=%b want 0 1", level, empty); end
        repeat (60) @(negedge clk);
        checks++; if (q.size() != 1 || q[0] !== 8'h30) begin errors++; $display("FAIL flush_inflight got %0d bytes want 1 (30)", q.size()); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_discard got level=%0d want 0", level); end
    endtask

    task automatic test_wrap;
        int sent, writes, bad, full_seen, exp_lvl, order_bad;
        logic pend;
        sent = 0; writes = 0; bad = 0; full_seen = 0; order_bad = 0; pend = 1'b0;
        busy_len = 1;
        q.delete();
        for (int cyc = 0; cyc < 1000 && q.size() < 40; cyc++) begin
            @(negedge clk);
            if (pend) writes++;
            exp_lvl = writes - (q.size() + (tx_en ? 1 : 0));
            if (level !== 5'(exp_lvl)) bad++;
            if (empty !== (exp_lvl == 0)) bad++;
            if (full) full_seen++;
            pend = (cyc % 3 == 0) && (sent < 40);
            wr_en = pend;
            if (pend) begin
                wr_data = 8'(sent);
                sent++;
            end
        end
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 40 && i < q.size(); i++) if (q[i] !== 8'(i)) order_bad++;
        checks++; if (q.size() != 40 || order_bad != 0) begin errors++; $display("FAIL wrap_stream got %0d bytes %0d wrong want 40 0", q.size(), order_bad); end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_level got %0d bad cycles want 0", bad); end
        checks++; if (full_seen != 0 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_full got full_cycles=%0d ovf=%b want 0 0", full_seen, overflow); end
    endtask

    task automatic test_thr;
        logic [CNT_W-1:0] prev;
        logic exp_irq;
        int bad;
        bad = 0;
        thr_level = 5'd2;
        launch_en = 1'b0;
        busy_len = 1;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h50 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
        checks++; if (thr_irq !== 1'b0) begin errors++; $display("FAIL thr_above got %b want 0 at level %0d", thr_irq, level); end
        launch_en = 1'b1;
        prev = level;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp_irq = THR_EN && (prev <= 5'd2);
            if (thr_irq !== exp_irq) bad++;
            prev = level;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL thr_track got %0d bad cycles want 0", bad); end
        checks++; if (thr_irq !== THR_EN) begin errors++; $display("FAIL thr_final got %b want %b", thr_irq, THR_EN); end
    endtask

    task automatic test_reset_mid;
        busy_len = 50;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (level !== 5'd0 || empty !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid got level=%0d empty=%b data=%h want 0 1 00", level, empty, tx_data); end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (q.size() != 1 || level !== 5'd0 || tx_en !== 1'b0) begin errors++; $display("FAIL rst_mid_after got bytes=%0d level=%0d tx_en=%b want 1 0 0", q.size(), level, tx_en); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_wrap();
        test_thr();
        test_reset_mid();
        checks++; if (busy_viol != 0 || width_viol != 0) begin errors++; $display("FAIL handshake_total got busy_viol=%0d width_viol=%0d want 0 0", busy_viol, width_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
